line_window_gen: RTL and testbench
==================================

Name: line_window_gen

Overview:
- Streaming K×K sliding-window generator for the CNN feature-map datapath.
- Successor to the fixed 3-tap single line buffer. Generalised in line width, frame height, kernel size and pixel width.
- Adds frame row/column tracking, valid-window qualification, per-frame end marker and frame restart.
- Sits between the pixel source and the convolution MAC array; outputs one complete window per accepted pixel once the window is fully inside the frame.

Parameters:
F, 28, line width in pixels (columns per row)
H, 28, frame height in rows
B, 8, pixel width in bits
K, 3, kernel size; legal range 2 <= K <= min(F,H)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_data  input  B  pixel, row-major raster order
i_data_valid  input  1  pixel accepted on this edge when high
i_sof  input  1  start of frame; restarts position tracking
o_window  output  K*K*B  window, registered
o_window_valid  output  1  o_window holds a new full in-frame window this cycle
o_window_last  output  1  last window of the frame; qualifies o_window_valid

Behaviour:
- Reset: async assert clears col/row counters to 0, o_window to 0, o_window_valid to 0, o_window_last to 0. Line memories are not reset; valid gating never exposes stale contents.
- Storage:
  - K-1 line memories of F×B.
  - K×K register window; each row shifts left on every accepted pixel.
  - New column = K-1 vertically aligned pixels from the line memories plus i_data.
  - i_data is written into the current line memory at the column pointer.
- Position: col counts 0..F-1, wraps at F-1 (never reaches F); row increments on col wrap, 0..H-1, wraps at H-1 back to 0.
- Window packing: element (i,j) occupies o_window[((K*K-1)-(i*K+j))*B +: B].
  - i = 0 is the oldest row, j = 0 the leftmost column; the top-left pixel sits in the MSBs.
  - Element (i,j) is the pixel at row r-K+1+i, col c-K+1+j.
- Latency: 1 cycle. When the pixel at (r,c) is accepted with r >= K-1 and c >= K-1, o_window_valid is high the next cycle. Valid (no-padding) convolution gives (F-K+1)*(H-K+1) windows per frame.
- o_window_last is high together with o_window_valid for the window at (H-1, F-1) only.
- No backpressure: with i_data_valid low, nothing shifts, counters hold, o_window holds its value, and o_window_valid / o_window_last go low next cycle.
- Frame boundary: after (H-1, F-1) the next pixel is (0,0). Rows of the previous frame never qualify a window; valid stays suppressed until (K-1, K-1).
- i_sof with i_data_valid: that pixel is placed at (0,0) regardless of the current position. Counters then continue from (0,1).
- i_sof without i_data_valid: counters clear to (0,0) and no pixel is written.
- A partial frame abandoned by i_sof emits no further windows and no o_window_last.
- Async reset mid-frame: outputs clear immediately and tracking restarts at (0,0) on the first valid pixel after release.

Test Plan:
1. F=H=4, K=3; pixels 0..15 back-to-back -> exactly 4 valid windows, following pixels 10, 11, 14 and 15. First window = {0,1,2,4,5,6,8,9,10}. Last = {5,6,7,9,10,11,13,14,15} with o_window_last=1.
2. Same stimulus with i_data_valid toggling 1/0 -> identical window sequence. Each valid is a single cycle one cycle after its accepted pixel; o_window is held during gaps.
3. Two frames back-to-back (0..15, then 16..31) -> no valid for pixels 16..25. Next window = {16,17,18,20,21,22,24,25,26}; no mixing of frame-1 data.
4. After 6 pixels of a frame, drive i_sof with pixel 100 followed by 101..115 -> pixel 100 is at (0,0). First window = {100,101,102,104,105,106,108,109,110}.
5. Assert i_rst asynchronously mid-frame (between clock edges) -> o_window_valid, o_window_last and o_window go to 0 before the next edge. The restarted frame behaves as in test 1.
6. Defaults (F=H=28, K=3); a 784-pixel ramp -> 676 valid windows, exactly one o_window_last, on the final window.

Source files
------------

// File: rtl/line_window_gen.sv
// Streaming KxK sliding-window generator.
// Pixels arrive in raster order. Each accepted pixel completes one new window
// column: the K-1 pixels stored above it in the line memories plus the pixel
// itself. A window is flagged valid only when the whole KxK neighbourhood lies
// inside the current frame. Because of that gating, stale line-memory contents
// from an earlier frame never reach a valid output.
module line_window_gen #(
  parameter int F = 28,  // columns per row
  parameter int H = 28,  // rows per frame
  parameter int B = 8,   // pixel width
  parameter int K = 3    // kernel size, 2 <= K <= min(F,H)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [B-1:0]       i_data,
  input  logic               i_data_valid,
  input  logic               i_sof,
  output logic [K*K*B-1:0]   o_window,
  output logic               o_window_valid,
  output logic               o_window_last
);

  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(F - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

  // Bit offset of window element (i,j); row 0 / column 0 sits in the MSBs.
  function automatic int elem_base(input int i, input int j);
    elem_base = ((K * K - 1) - (i * K + j)) * B;
  endfunction

  // Position tracking
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] col_cur_s;   // column of the pixel on the bus this cycle
  logic [RW-1:0] row_cur_s;   // row of the pixel on the bus this cycle
  logic [CW-1:0] col_nxt_s;
  logic [RW-1:0] row_nxt_s;
  logic          win_ok_s;    // accepted pixel completes an in-frame window
  logic          frame_end_s; // accepted pixel is the last one of the frame

  // Line memories: index 0 holds the row just above the current one,
  // index K-2 holds the oldest row of the window.
  logic [B-1:0]  line_mem_r [K-1][F];

  // Window datapath
  logic [B-1:0]     new_col_s [K];
  logic [K*K*B-1:0] win_nxt_s;

  // Resolve the current pixel position (start-of-frame forces 0,0) and the next counter values.
  always_comb begin
    col_cur_s   = col_r;
    row_cur_s   = row_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    win_ok_s    = 1'b0;
    frame_end_s = 1'b0;

    if (i_sof) begin
      col_cur_s = '0;
      row_cur_s = '0;
    end else begin
      col_cur_s = col_r;
      row_cur_s = row_r;
    end

    if (i_data_valid) begin
      if (col_cur_s == COL_LAST) begin
        col_nxt_s = '0;
        if (row_cur_s == ROW_LAST) begin
          row_nxt_s = '0;
        end else begin
          row_nxt_s = row_cur_s + RW'(1);
        end
      end else begin
        col_nxt_s = col_cur_s + CW'(1);
        row_nxt_s = row_cur_s;
      end
      win_ok_s    = (row_cur_s >= ROW_WIN) && (col_cur_s >= COL_WIN);
      frame_end_s = (row_cur_s == ROW_LAST) && (col_cur_s == COL_LAST);
    end else begin
      // No pixel: hold position, except that a bare start-of-frame rewinds to 0,0.
      col_nxt_s = col_cur_s;
      row_nxt_s = row_cur_s;
    end
  end

  // Column/row counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_r <= '0;
      row_r <= '0;
    end else begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
    end
  end

  // Line memories shift down by one row at the current column; not reset, outputs are gated instead.
  always_ff @(posedge i_clk) begin
    if (i_data_valid) begin
      for (int k = K - 2; k > 0; k--) begin
        line_mem_r[k][col_cur_s] <= line_mem_r[k-1][col_cur_s];
      end
      line_mem_r[0][col_cur_s] <= i_data;
    end
  end

  // Assemble the incoming window column, oldest row first.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      new_col_s[i] = i_data;
    end
    for (int i = 0; i < K - 1; i++) begin
      new_col_s[i] = line_mem_r[K-2-i][col_cur_s];
    end
  end

  // Shift every window row left by one element and append the new column on the right.
  always_comb begin
    win_nxt_s = o_window;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (j < K - 1) begin
          win_nxt_s[elem_base(i, j) +: B] = o_window[elem_base(i, j + 1) +: B];
        end else begin
          win_nxt_s[elem_base(i, j) +: B] = new_col_s[i];
        end
      end
    end
  end

  // Registered window and qualifiers; the window holds while no pixel is accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_window_last  <= 1'b0;
    end else if (i_data_valid) begin
      o_window       <= win_nxt_s;
      o_window_valid <= win_ok_s;
      o_window_last  <= frame_end_s;
    end else begin
      o_window_valid <= 1'b0;
      o_window_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Self-checking bench for line_window_gen: a 4x4/K=3 instance checked against
// a frame-image scoreboard, and a default 28x28/K=3 instance checked on a ramp.
module tb_line_window_gen;

  logic clk;
  logic rst;

  // Small instance (F=H=4, K=3)
  logic [7:0]  s_data;
  logic        s_dv;
  logic        s_sof;
  logic [71:0] s_win;
  logic        s_ov;
  logic        s_last;

  // Default instance (F=H=28, K=3)
  logic [7:0]  d_data;
  logic        d_dv;
  logic        d_sof;
  logic [71:0] d_win;
  logic        d_ov;
  logic        d_last;

  int n_tests;
  int n_fail;
  int cyc;

  typedef struct {
    logic [71:0] win;
    logic        last;
    int          cyc;
  } sb_t;

  sb_t         sb_q[$];
  logic [71:0] obs_log[$];
  logic [71:0] last_exp;
  int          s_last_cnt;
  bit          prev_dv;
  bit          prev_ov;

  int img[4][4];
  int mr;
  int mc;

  int d_cnt;
  int d_last_cnt;

  line_window_gen #(.F(4), .H(4), .B(8), .K(3)) u_small (
    .i_clk(clk), .i_rst(rst), .i_data(s_data), .i_data_valid(s_dv), .i_sof(s_sof),
    .o_window(s_win), .o_window_valid(s_ov), .o_window_last(s_last)
  );

  line_window_gen u_dflt (
    .i_clk(clk), .i_rst(rst), .i_data(d_data), .i_data_valid(d_dv), .i_sof(d_sof),
    .o_window(d_win), .o_window_valid(d_ov), .o_window_last(d_last)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to verify one-cycle latency.
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int p[9]);
    logic [71:0] res;
    res = '0;
    for (int n = 0; n < 9; n++) res[(8 - n) * 8 +: 8] = 8'(p[n]);
    return res;
  endfunction

  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] res;
    int v;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v = img[r - 2 + i][c - 2 + j];
        res[(8 - (i * 3 + j)) * 8 +: 8] = v[7:0];
      end
    end
    return res;
  endfunction

  // Drive one accepted pixel into the small instance and update the model.
  task automatic drive_pix(input int d, input bit sof);
    sb_t e;
    s_data = 8'(d);
    s_dv   = 1'b1;
    s_sof  = sof;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = d & 255;
    if (mr >= 2 && mc >= 2) begin
      e.win  = model_win(mr, mc);
      e.last = (mr == 3 && mc == 3);
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
    if (mc == 3) begin
      mc = 0;
      mr = (mr == 3) ? 0 : mr + 1;
    end else begin
      mc++;
    end
    @(posedge clk); #1;
    s_sof = 1'b0;
  endtask

  // Idle cycles on the small instance, optionally with a bare start-of-frame on the first.
  task automatic idle(input int n, input bit sof);
    s_dv  = 1'b0;
    s_sof = sof;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      s_sof = 1'b0;
    end
  endtask

  task automatic begin_test();
    obs_log.delete();
    s_last_cnt = 0;
  endtask

  task automatic frame_checks(input string tag);
    int a_first[9];
    int a_last[9];
    a_first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    a_last  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    chk({tag, "_cnt"}, obs_log.size(), 4);
    chk({tag, "_lastcnt"}, s_last_cnt, 1);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
    if (obs_log.size() == 4) begin
      chk({tag, "_first"}, obs_log[0], pack9(a_first));
      chk({tag, "_final"}, obs_log[3], pack9(a_last));
    end
  endtask

  // Scoreboard monitor for the small instance, sampled away from the active edge.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      prev_dv = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (s_ov) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("window", s_win, e.win);
          chk("last", s_last, e.last);
          chk("latency", cyc, e.cyc);
          last_exp = e.win;
          obs_log.push_back(s_win);
          if (s_last) s_last_cnt++;
        end
      end else begin
        chk("last_gated", s_last, 1'b0);
        if (!prev_dv && prev_ov) chk("hold", s_win, last_exp);
      end
      prev_ov = s_ov;
      prev_dv = s_dv;
    end
  end

  // Monitor for the default instance: windows arrive in raster order of their bottom-right pixel.
  always @(negedge clk) begin
    logic [71:0] exp_w;
    int wr;
    int wc;
    int v;
    if (!rst && d_ov) begin
      wr = 2 + d_cnt / 26;
      wc = 2 + d_cnt % 26;
      exp_w = '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          v = ((wr - 2 + i) * 28 + (wc - 2 + j)) & 255;
          exp_w[(8 - (i * 3 + j)) * 8 +: 8] = v[7:0];
        end
      end
      chk("t6_win", d_win, exp_w);
      chk("t6_last", d_last, (d_cnt == 675));
      if (d_last) d_last_cnt++;
      d_cnt++;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int a[9];
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    mr = 0;
    mc = 0;
    last_exp = '0;
    d_cnt = 0;
    d_last_cnt = 0;
    rst    = 1'b1;
    s_data = 8'd0; s_dv = 1'b0; s_sof = 1'b0;
    d_data = 8'd0; d_dv = 1'b0; d_sof = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", s_ov, 1'b0);
    chk("rst_last", s_last, 1'b0);
    chk("rst_window", s_win, 72'd0);
    chk("rst_dflt_valid", d_ov, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: one frame back-to-back
    begin_test();
    for (int p = 0; p < 16; p++) drive_pix(p, 1'b0);
    idle(3, 1'b0);
    frame_checks("t1");

    // Test 2: valid toggling 1/0
    begin_test();
    for (int p = 0; p < 16; p++) begin
      drive_pix(p, 1'b0);
      idle(1, 1'b0);
    end
    idle(2, 1'b0);
    frame_checks("t2");

    // Test 3: two frames back-to-back
    begin_test();
    for (int p = 0; p < 32; p++) drive_pix(p, 1'b0);
    idle(3, 1'b0);
    chk("t3_cnt", obs_log.size(), 8);
    chk("t3_lastcnt", s_last_cnt, 2);
    chk("t3_sb_empty", sb_q.size(), 0);
    a = '{16, 17, 18, 20, 21, 22, 24, 25, 26};
    if (obs_log.size() == 8) chk("t3_frame2_first", obs_log[4], pack9(a));

    // Test 4: start-of-frame with a pixel mid-frame
    begin_test();
    for (int p = 200; p < 206; p++) drive_pix(p, 1'b0);
    drive_pix(100, 1'b1);
    for (int p = 101; p < 116; p++) drive_pix(p, 1'b0);
    idle(3, 1'b0);
    chk("t4_cnt", obs_log.size(), 4);
    chk("t4_lastcnt", s_last_cnt, 1);
    chk("t4_sb_empty", sb_q.size(), 0);
    a = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
    if (obs_log.size() == 4) chk("t4_first", obs_log[0], pack9(a));

    // Test 4b: partial frame abandoned by a bare start-of-frame
    begin_test();
    for (int p = 0; p < 12; p++) drive_pix(p, 1'b0);
    idle(2, 1'b1);
    for (int p = 0; p < 16; p++) drive_pix(p, 1'b0);
    idle(3, 1'b0);
    chk("t4b_cnt", obs_log.size(), 6);
    chk("t4b_lastcnt", s_last_cnt, 1);
    chk("t4b_sb_empty", sb_q.size(), 0);

    // Test 5: asynchronous reset between clock edges
    begin_test();
    for (int p = 0; p < 11; p++) drive_pix(p, 1'b0);
    s_dv = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", s_ov, 1'b0);
    chk("t5_rst_last", s_last, 1'b0);
    chk("t5_rst_window", s_win, 72'd0);
    sb_q.delete();
    mr = 0;
    mc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    begin_test();
    for (int p = 0; p < 16; p++) drive_pix(p, 1'b0);
    idle(3, 1'b0);
    frame_checks("t5");

    // Test 6: default parameters, 784-pixel ramp
    for (int p = 0; p < 784; p++) begin
      d_data = 8'(p & 255);
      d_dv   = 1'b1;
      @(posedge clk); #1;
    end
    d_dv = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t6_cnt", d_cnt, 676);
    chk("t6_lastcnt", d_last_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
